// File: rtl/csr_file_pkg.sv
// Shared constants and types for the machine-mode CSR file: addresses, bit indices, cause codes.
package csr_file_pkg;

  localparam int CSR_XLEN = 64;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_MSI      = 3;
  localparam int IRQ_MTI      = 7;
  localparam int IRQ_MEI      = 11;

  localparam logic [3:0] IRQ_CODE_NONE  = 4'd0;
  localparam logic [3:0] IRQ_CODE_SOFT  = 4'd3;
  localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;
  localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  // Same three-bit layout serves mie (enables) and mip (pending).
  typedef struct packed {
    logic mei;
    logic mti;
    logic msi;
  } irq_vec_t;

  function automatic logic [CSR_XLEN-1:0] mstatus_to_xlen(mstatus_t s);
    logic [CSR_XLEN-1:0] r;
    r               = '0;
    r[12:11]        = 2'b11;
    r[MSTATUS_MIE]  = s.mie;
    r[MSTATUS_MPIE] = s.mpie;
    return r;
  endfunction

  function automatic logic [CSR_XLEN-1:0] irq_to_xlen(irq_vec_t v);
    logic [CSR_XLEN-1:0] r;
    r          = '0;
    r[IRQ_MSI] = v.msi;
    r[IRQ_MTI] = v.mti;
    r[IRQ_MEI] = v.mei;
    return r;
  endfunction

  function automatic logic [3:0] irq_prio(irq_vec_t v);
    if (v.mei)      return IRQ_CODE_EXT;
    else if (v.msi) return IRQ_CODE_SOFT;
    else if (v.mti) return IRQ_CODE_TIMER;
    else            return IRQ_CODE_NONE;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running counter with synchronous load; a load takes precedence over that cycle's increment.
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)     count_d = wdata_i;
    else if (inc_i) count_d = count_q + 1'b1;
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR register file: execute-stage read port, writeback writes, trap/mret stacking, irq request.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int               XLEN        = CSR_XLEN,
  parameter logic [XLEN-1:0]  MTVEC_RESET = '0,
  parameter logic [XLEN-1:0]  HART_ID     = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [11:0]     csr_ridx_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            csr_wen_i,
  input  logic [11:0]     csr_widx_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            mcause_wen_i,
  input  logic [XLEN-1:0] mcause_wdata_i,
  input  logic            mtval_wen_i,
  input  logic [XLEN-1:0] mtval_wdata_i,
  input  logic            mepc_wen_i,
  input  logic [XLEN-1:0] mepc_wdata_i,
  input  logic            mret_i,
  input  logic            instret_i,
  input  logic            irq_timer_i,
  input  logic            irq_soft_i,
  input  logic            irq_ext_i,
  output logic [XLEN-1:0] mtvec_rdata_o,
  output logic [XLEN-1:0] mepc_rdata_o,
  output logic            irq_req_o,
  output logic [3:0]      irq_code_o
);

  mstatus_t        mstatus_q, mstatus_d;
  irq_vec_t        mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            irq_req_q, irq_req_d;
  logic [3:0]      irq_code_q, irq_code_d;

  irq_vec_t mip_live;
  irq_vec_t irq_pending;

  assign mip_live    = irq_vec_t'({irq_ext_i, irq_timer_i, irq_soft_i});
  assign irq_pending = irq_vec_t'(mie_q & mip_live);

  // Low bits of mepc_wdata_i are forced to zero on capture.
  logic unused_mepc_lsb;
  assign unused_mepc_lsb = ^mepc_wdata_i[1:0];

`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle, minstret;

  csr_counter #(.WIDTH(XLEN)) u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .load_i  (csr_wen_i && (csr_widx_i == CSR_MCYCLE)),
    .wdata_i (csr_wdata_i),
    .count_o (mcycle)
  );

  csr_counter #(.WIDTH(XLEN)) u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (instret_i),
    .load_i  (csr_wen_i && (csr_widx_i == CSR_MINSTRET)),
    .wdata_i (csr_wdata_i),
    .count_o (minstret)
  );
`else
  logic unused_instret;
  assign unused_instret = instret_i;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;

    if (csr_wen_i) begin
      case (csr_widx_i)
        CSR_MSTATUS: begin
          mstatus_d.mie  = csr_wdata_i[MSTATUS_MIE];
          mstatus_d.mpie = csr_wdata_i[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = irq_vec_t'({csr_wdata_i[IRQ_MEI], csr_wdata_i[IRQ_MTI],
                                               csr_wdata_i[IRQ_MSI]});
        CSR_MTVEC:    mtvec_d    = {csr_wdata_i[XLEN-1:2], 2'b00};
        CSR_MSCRATCH: mscratch_d = csr_wdata_i;
        CSR_MEPC:     mepc_d     = {csr_wdata_i[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = csr_wdata_i;
        CSR_MTVAL:    mtval_d    = csr_wdata_i;
        default: ;
      endcase
    end

    // Trap/mret updates come after the instruction write so they win on a collision.
    if (mepc_wen_i) begin
      mepc_d         = {mepc_wdata_i[XLEN-1:2], 2'b00};
      mstatus_d.mpie = mstatus_q.mie;
      mstatus_d.mie  = 1'b0;
    end else if (mret_i) begin
      mstatus_d.mie  = mstatus_q.mpie;
      mstatus_d.mpie = 1'b1;
    end
    if (mcause_wen_i) mcause_d = mcause_wdata_i;
    if (mtval_wen_i)  mtval_d  = mtval_wdata_i;

    irq_req_d  = mstatus_q.mie & (|irq_pending);
    irq_code_d = irq_prio(irq_pending);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      irq_req_q  <= 1'b0;
      irq_code_q <= IRQ_CODE_NONE;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      irq_req_q  <= irq_req_d;
      irq_code_q <= irq_code_d;
    end
  end

  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_ridx_i)
      CSR_MSTATUS:  csr_rdata_o = mstatus_to_xlen(mstatus_q);
      CSR_MISA:     csr_rdata_o = '0;
      CSR_MIE:      csr_rdata_o = irq_to_xlen(mie_q);
      CSR_MTVEC:    csr_rdata_o = mtvec_q;
      CSR_MSCRATCH: csr_rdata_o = mscratch_q;
      CSR_MEPC:     csr_rdata_o = mepc_q;
      CSR_MCAUSE:   csr_rdata_o = mcause_q;
      CSR_MTVAL:    csr_rdata_o = mtval_q;
      CSR_MIP:      csr_rdata_o = irq_to_xlen(mip_live);
      CSR_MHARTID:  csr_rdata_o = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   csr_rdata_o = mcycle;
      CSR_MINSTRET: csr_rdata_o = minstret;
`else
      CSR_MCYCLE, CSR_MINSTRET: csr_rdata_o = '0;
`endif
      default:      csr_illegal_o = 1'b1;
    endcase
  end

  assign mtvec_rdata_o = mtvec_q;
  assign mepc_rdata_o  = mepc_q;
  assign irq_req_o     = irq_req_q;
  assign irq_code_o    = irq_code_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; counter expectations follow CSR_COUNTERS_EN.
module tb_csr_file;

  localparam logic [63:0] TB_MTVEC_RESET = 64'h0000_0000_0000_0200;
  localparam logic [63:0] TB_HART_ID     = 64'd3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] csr_ridx_i;
  logic [63:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        csr_wen_i;
  logic [11:0] csr_widx_i;
  logic [63:0] csr_wdata_i;
  logic        mcause_wen_i;
  logic [63:0] mcause_wdata_i;
  logic        mtval_wen_i;
  logic [63:0] mtval_wdata_i;
  logic        mepc_wen_i;
  logic [63:0] mepc_wdata_i;
  logic        mret_i;
  logic        instret_i;
  logic        irq_timer_i;
  logic        irq_soft_i;
  logic        irq_ext_i;
  logic [63:0] mtvec_rdata_o;
  logic [63:0] mepc_rdata_o;
  logic        irq_req_o;
  logic [3:0]  irq_code_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  csr_file #(
    .XLEN        (64),
    .MTVEC_RESET (TB_MTVEC_RESET),
    .HART_ID     (TB_HART_ID)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .csr_ridx_i     (csr_ridx_i),
    .csr_rdata_o    (csr_rdata_o),
    .csr_illegal_o  (csr_illegal_o),
    .csr_wen_i      (csr_wen_i),
    .csr_widx_i     (csr_widx_i),
    .csr_wdata_i    (csr_wdata_i),
    .mcause_wen_i   (mcause_wen_i),
    .mcause_wdata_i (mcause_wdata_i),
    .mtval_wen_i    (mtval_wen_i),
    .mtval_wdata_i  (mtval_wdata_i),
    .mepc_wen_i     (mepc_wen_i),
    .mepc_wdata_i   (mepc_wdata_i),
    .mret_i         (mret_i),
    .instret_i      (instret_i),
    .irq_timer_i    (irq_timer_i),
    .irq_soft_i     (irq_soft_i),
    .irq_ext_i      (irq_ext_i),
    .mtvec_rdata_o  (mtvec_rdata_o),
    .mepc_rdata_o   (mepc_rdata_o),
    .irq_req_o      (irq_req_o),
    .irq_code_o     (irq_code_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [11:0] addr);
    csr_ridx_i = addr;
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [63:0] data);
    csr_wen_i   = 1'b1;
    csr_widx_i  = addr;
    csr_wdata_i = data;
    tick();
    csr_wen_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    total_cnt++;
    if (mtvec_rdata_o !== TB_MTVEC_RESET) $display("FAIL reset_mtvec: got %h want %h", mtvec_rdata_o, TB_MTVEC_RESET);
    else pass_cnt++;
    rd(12'h300);
    total_cnt++;
    if (csr_rdata_o !== 64'h1800) $display("FAIL reset_mstatus: got %h want %h", csr_rdata_o, 64'h1800);
    else pass_cnt++;
    rd(12'hF14);
    total_cnt++;
    if (csr_rdata_o !== TB_HART_ID || csr_illegal_o !== 1'b0)
      $display("FAIL reset_mhartid: got %h/%b want %h/0", csr_rdata_o, csr_illegal_o, TB_HART_ID);
    else pass_cnt++;
    total_cnt++;
    if (irq_req_o !== 1'b0 || irq_code_o !== 4'd0)
      $display("FAIL reset_irq: got req=%b code=%0d want req=0 code=0", irq_req_o, irq_code_o);
    else pass_cnt++;
    rd(12'h341);
    total_cnt++;
    if (csr_rdata_o !== 64'h0 || mepc_rdata_o !== 64'h0)
      $display("FAIL reset_mepc: got %h/%h want 0/0", csr_rdata_o, mepc_rdata_o);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    csr_wr(12'h305, 64'h8000_0103);
    total_cnt++;
    if (mtvec_rdata_o !== 64'h8000_0100) $display("FAIL mtvec_warl: got %h want %h", mtvec_rdata_o, 64'h8000_0100);
    else pass_cnt++;
    rd(12'h7C0);
    total_cnt++;
    if (csr_rdata_o !== 64'h0 || csr_illegal_o !== 1'b1)
      $display("FAIL illegal_addr: got %h/%b want 0/1", csr_rdata_o, csr_illegal_o);
    else pass_cnt++;
    // Write not yet visible in the cycle it is presented.
    csr_wen_i = 1'b1; csr_widx_i = 12'h340; csr_wdata_i = 64'hDEAD_BEEF_1234_5678;
    rd(12'h340);
    total_cnt++;
    if (csr_rdata_o !== 64'h0) $display("FAIL no_bypass: got %h want %h", csr_rdata_o, 64'h0);
    else pass_cnt++;
    tick();
    csr_wen_i = 1'b0;
    rd(12'h340);
    total_cnt++;
    if (csr_rdata_o !== 64'hDEAD_BEEF_1234_5678) $display("FAIL mscratch: got %h want %h", csr_rdata_o, 64'hDEAD_BEEF_1234_5678);
    else pass_cnt++;
    csr_wr(12'h301, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'h301);
    total_cnt++;
    if (csr_rdata_o !== 64'h0 || csr_illegal_o !== 1'b0)
      $display("FAIL misa_ro: got %h/%b want 0/0", csr_rdata_o, csr_illegal_o);
    else pass_cnt++;
    csr_wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'h300);
    total_cnt++;
    if (csr_rdata_o !== 64'h1888) $display("FAIL mstatus_warl: got %h want %h", csr_rdata_o, 64'h1888);
    else pass_cnt++;
    csr_wr(12'h300, 64'h0);
    rd(12'h300);
    total_cnt++;
    if (csr_rdata_o !== 64'h1800) $display("FAIL mstatus_clear: got %h want %h", csr_rdata_o, 64'h1800);
    else pass_cnt++;
    csr_wr(12'h304, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'h304);
    total_cnt++;
    if (csr_rdata_o !== 64'h888) $display("FAIL mie_warl: got %h want %h", csr_rdata_o, 64'h888);
    else pass_cnt++;
    csr_wr(12'h304, 64'h0);
  endtask

  task automatic test_trap();
    csr_wr(12'h300, 64'h8);
    mepc_wen_i = 1'b1;   mepc_wdata_i   = 64'h1006;
    mcause_wen_i = 1'b1; mcause_wdata_i = 64'd2;
    mtval_wen_i = 1'b1;  mtval_wdata_i  = 64'h55;
    tick();
    mepc_wen_i = 1'b0; mcause_wen_i = 1'b0; mtval_wen_i = 1'b0;
    rd(12'h341);
    total_cnt++;
    if (csr_rdata_o !== 64'h1004 || mepc_rdata_o !== 64'h1004)
      $display("FAIL trap_mepc: got %h/%h want %h", csr_rdata_o, mepc_rdata_o, 64'h1004);
    else pass_cnt++;
    rd(12'h342);
    total_cnt++;
    if (csr_rdata_o !== 64'd2) $display("FAIL trap_mcause: got %h want %h", csr_rdata_o, 64'd2);
    else pass_cnt++;
    rd(12'h343);
    total_cnt++;
    if (csr_rdata_o !== 64'h55) $display("FAIL trap_mtval: got %h want %h", csr_rdata_o, 64'h55);
    else pass_cnt++;
    rd(12'h300);
    total_cnt++;
    if (csr_rdata_o !== 64'h1880) $display("FAIL trap_mstatus: got %h want %h", csr_rdata_o, 64'h1880);
    else pass_cnt++;
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    rd(12'h300);
    total_cnt++;
    if (csr_rdata_o !== 64'h1888) $display("FAIL mret_mstatus: got %h want %h", csr_rdata_o, 64'h1888);
    else pass_cnt++;
    // Trap entry and mret together: trap entry wins.
    mret_i = 1'b1; mepc_wen_i = 1'b1; mepc_wdata_i = 64'h2000;
    tick();
    mret_i = 1'b0; mepc_wen_i = 1'b0;
    rd(12'h300);
    total_cnt++;
    if (csr_rdata_o !== 64'h1880 || mepc_rdata_o !== 64'h2000)
      $display("FAIL trap_beats_mret: got %h/%h want %h/%h", csr_rdata_o, mepc_rdata_o, 64'h1880, 64'h2000);
    else pass_cnt++;
  endtask

  task automatic test_irq();
    csr_wr(12'h304, 64'h888);
    csr_wr(12'h300, 64'h8);
    irq_timer_i = 1'b1; irq_ext_i = 1'b1;
    rd(12'h344);
    total_cnt++;
    if (csr_rdata_o !== 64'h880) $display("FAIL mip_live: got %h want %h", csr_rdata_o, 64'h880);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (irq_req_o !== 1'b1 || irq_code_o !== 4'd11)
      $display("FAIL irq_ext_prio: got req=%b code=%0d want req=1 code=11", irq_req_o, irq_code_o);
    else pass_cnt++;
    irq_ext_i = 1'b0;
    tick();
    total_cnt++;
    if (irq_req_o !== 1'b1 || irq_code_o !== 4'd7)
      $display("FAIL irq_timer: got req=%b code=%0d want req=1 code=7", irq_req_o, irq_code_o);
    else pass_cnt++;
    irq_soft_i = 1'b1;
    tick();
    total_cnt++;
    if (irq_req_o !== 1'b1 || irq_code_o !== 4'd3)
      $display("FAIL irq_soft_prio: got req=%b code=%0d want req=1 code=3", irq_req_o, irq_code_o);
    else pass_cnt++;
    // Trap entry clears MIE; the request drops one cycle after that takes effect.
    mepc_wen_i = 1'b1; mepc_wdata_i = 64'h3000;
    tick();
    mepc_wen_i = 1'b0;
    total_cnt++;
    if (irq_req_o !== 1'b1) $display("FAIL irq_trap_edge: got req=%b want req=1", irq_req_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (irq_req_o !== 1'b0) $display("FAIL irq_trap_drop: got req=%b want req=0", irq_req_o);
    else pass_cnt++;
    irq_timer_i = 1'b0;
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    csr_wr(12'h304, 64'h80);
    tick();
    total_cnt++;
    if (irq_req_o !== 1'b0 || irq_code_o !== 4'd0)
      $display("FAIL irq_masked: got req=%b code=%0d want req=0 code=0", irq_req_o, irq_code_o);
    else pass_cnt++;
    irq_soft_i = 1'b0;
  endtask

  task automatic test_counters();
    csr_wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    rd(12'hB00);
`ifdef CSR_COUNTERS_EN
    total_cnt++;
    if (csr_rdata_o !== 64'hFFFF_FFFF_FFFF_FFFE || csr_illegal_o !== 1'b0)
      $display("FAIL mcycle_load: got %h/%b want %h/0", csr_rdata_o, csr_illegal_o, 64'hFFFF_FFFF_FFFF_FFFE);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (csr_rdata_o !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL mcycle_inc: got %h want %h", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (csr_rdata_o !== 64'h0) $display("FAIL mcycle_wrap: got %h want %h", csr_rdata_o, 64'h0);
    else pass_cnt++;
    instret_i = 1'b1;
    csr_wr(12'hB02, 64'd5);
    rd(12'hB02);
    total_cnt++;
    if (csr_rdata_o !== 64'd5) $display("FAIL minstret_load: got %h want %h", csr_rdata_o, 64'd5);
    else pass_cnt++;
    tick();
    instret_i = 1'b0;
    total_cnt++;
    if (csr_rdata_o !== 64'd6) $display("FAIL minstret_inc: got %h want %h", csr_rdata_o, 64'd6);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (csr_rdata_o !== 64'd6) $display("FAIL minstret_hold: got %h want %h", csr_rdata_o, 64'd6);
    else pass_cnt++;
`else
    total_cnt++;
    if (csr_rdata_o !== 64'h0 || csr_illegal_o !== 1'b0)
      $display("FAIL mcycle_absent: got %h/%b want 0/0", csr_rdata_o, csr_illegal_o);
    else pass_cnt++;
    instret_i = 1'b1;
    csr_wr(12'hB02, 64'd5);
    instret_i = 1'b0;
    rd(12'hB02);
    total_cnt++;
    if (csr_rdata_o !== 64'h0 || csr_illegal_o !== 1'b0)
      $display("FAIL minstret_absent: got %h/%b want 0/0", csr_rdata_o, csr_illegal_o);
    else pass_cnt++;
`endif
  endtask

  task automatic test_collision();
    mcause_wen_i = 1'b1; mcause_wdata_i = 64'd11;
    csr_wr(12'h342, 64'd5);
    mcause_wen_i = 1'b0;
    rd(12'h342);
    total_cnt++;
    if (csr_rdata_o !== 64'd11) $display("FAIL mcause_collision: got %h want %h", csr_rdata_o, 64'd11);
    else pass_cnt++;
    mepc_wen_i = 1'b1; mepc_wdata_i = 64'h4444;
    csr_wr(12'h341, 64'h8888);
    mepc_wen_i = 1'b0;
    total_cnt++;
    if (mepc_rdata_o !== 64'h4444) $display("FAIL mepc_collision: got %h want %h", mepc_rdata_o, 64'h4444);
    else pass_cnt++;
    // A trap strobe does not block an instruction write to an unrelated CSR.
    mepc_wen_i = 1'b1; mepc_wdata_i = 64'h5000;
    csr_wr(12'h340, 64'h0BAD_F00D);
    mepc_wen_i = 1'b0;
    rd(12'h340);
    total_cnt++;
    if (csr_rdata_o !== 64'h0BAD_F00D || mepc_rdata_o !== 64'h5000)
      $display("FAIL other_csr_write: got %h/%h want %h/%h", csr_rdata_o, mepc_rdata_o, 64'h0BAD_F00D, 64'h5000);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rst_i = 1'b1;
    csr_wr(12'h340, 64'hAAAA_AAAA);
    rst_i = 1'b0;
    rd(12'h340);
    total_cnt++;
    if (csr_rdata_o !== 64'h0) $display("FAIL midreset_discard: got %h want %h", csr_rdata_o, 64'h0);
    else pass_cnt++;
    rd(12'h300);
    total_cnt++;
    if (csr_rdata_o !== 64'h1800 || mtvec_rdata_o !== TB_MTVEC_RESET)
      $display("FAIL midreset_state: got %h/%h want %h/%h", csr_rdata_o, mtvec_rdata_o, 64'h1800, TB_MTVEC_RESET);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; csr_ridx_i = '0;
    csr_wen_i = 1'b0; csr_widx_i = '0; csr_wdata_i = '0;
    mcause_wen_i = 1'b0; mcause_wdata_i = '0;
    mtval_wen_i = 1'b0; mtval_wdata_i = '0;
    mepc_wen_i = 1'b0; mepc_wdata_i = '0;
    mret_i = 1'b0; instret_i = 1'b0;
    irq_timer_i = 1'b0; irq_soft_i = 1'b0; irq_ext_i = 1'b0;
    test_reset();
    test_write_read();
    test_trap();
    test_irq();
    test_counters();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
